mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
Multi-cycle control unit for the RV32I multi-cycle CPU. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives datapath enables and mux selects, including pc_source into the PC-select mux.
- PC-select mux rule: next_pc = alu_out when (pc_source | bcond), else alu_out_reg.
- Consumes bcond from the ALU and produces the final PC write enable.

Parameters:
- MEM_LATENCY, 1, cycles each memory access is held (1..15); governs IF, load and store state dwell.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- opcode  in  7  IR[6:0]
- bcond  in  1  ALU branch-condition result
- halt_req  in  1  register x17 == 10 (ECALL halt condition)
- pc_write_en  out  1  final PC register enable
- pc_source  out  1  to PC mux; 1 = force alu_out
- i_or_d  out  1  memory address select; 0 = PC, 1 = alu_out
- mem_read  out  1  memory read
- mem_write  out  1  memory write
- ir_write  out  1  latch IR
- mdr_write  out  1  latch memory data register
- alu_out_reg_write  out  1  latch alu_out_reg
- alu_src_a  out  1  0 = PC, 1 = rs1 reg
- alu_src_b  out  2  00 = rs2 reg, 01 = const 4, 10 = imm
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded
- reg_write  out  1  register file write
- wb_sel  out  2  00 = alu_out (combinational), 01 = MDR, 10 = alu_out_reg
- is_halted  out  1  sticky halt
- retired_count  out  32  present only with MC_CTRL_STATS_EN
- cycle_count  out  32  present only with MC_CTRL_STATS_EN

Behaviour:
- Reset (reset == 0 at a clk edge): state = IF, wait counter = 0, is_halted = 0. Takes effect even mid-access; the in-flight access is abandoned and no enable is asserted in the reset cycle.
- All outputs are a Moore decode of the state, plus wait-counter qualification.
- Defaults: all enables = 0, all selects = 0.
- Wait counter:
  - Counts 0..MEM_LATENCY-1 in IF, EX_LD and EX_ST.
  - Advances state only when count == MEM_LATENCY-1.
  - Clears to 0 on every state change.
- IF: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00. On the final count, ir_write = 1 and alu_out_reg_write = 1, so alu_out_reg holds PC+4. Next state: ID.
- ID: no enables asserted. Next state by opcode:
  - 0110011 → EX_R
  - 0010011 → EX_I
  - 0000011 → EX_LD
  - 0100011 → EX_ST
  - 1100011 → EX_BR1
  - 1101111 → EX_JAL
  - 1100111 → EX_JALR
  - 1110011: if halt_req → HALT, else → EX_NOP
  - any other opcode → EX_NOP
- EX_R / EX_I: alu_src_a = 1, alu_src_b = 00 (EX_R) or 10 (EX_I), alu_op = 10, reg_write = 1, wb_sel = 00, pc_write_en = 1, pc_source = 0 → PC = PC+4. Next state: IF.
- EX_LD: alu_src_a = 1, alu_src_b = 10, alu_op = 00, i_or_d = 1, mem_read = 1. mdr_write = 1 on the final count. Next state: WB_LD.
- WB_LD: reg_write = 1, wb_sel = 01, pc_write_en = 1, pc_source = 0. Next state: IF.
- EX_ST: address as in EX_LD, mem_write = 1 every cycle. pc_write_en = 1 on the final count. Next state: IF.
- EX_BR1: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 0.
  - bcond = 0: pc_write_en = 1 (PC = PC+4), next state IF.
  - bcond = 1: pc_write_en = 0, next state EX_BR2.
- EX_BR2: alu_src_a = 0, alu_src_b = 10, alu_op = 00, pc_source = 1, pc_write_en = 1. Next state: IF.
- EX_JAL: alu_src_a = 0, alu_src_b = 10, alu_op = 00, reg_write = 1, wb_sel = 10, pc_source = 1, pc_write_en = 1. Next state: IF.
- EX_JALR: as EX_JAL but alu_src_a = 1.
- EX_NOP: pc_write_en = 1, pc_source = 0. Next state: IF.
- HALT: all enables 0, is_halted = 1, self-loop until reset.
- bcond is sampled only in EX_BR1. In every other state with pc_source = 0, alu_op != 01, so the ALU guarantees bcond = 0 and the mux selects alu_out_reg.
- alu_out_reg_write is asserted only in IF.

Optional Feature:
MC_CTRL_STATS_EN
- Defined: 32-bit cycle_count and retired_count ports exist.
  - cycle_count increments every non-reset cycle while not halted.
  - retired_count increments on each cycle where the state returns to IF (EX_* or WB_LD → IF), and once on entry to HALT.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both ports and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
- MEM_LATENCY = 1, opcode 0110011 → states IF, ID, EX_R; pc_write_en = 1 and reg_write = 1 only in cycle 3, pc_source = 0; 3 cycles total.
- Load (0000011), MEM_LATENCY = 3 → IF holds 3 cycles with ir_write only in the 3rd; EX_LD holds 3 cycles with mdr_write only in the last; WB_LD asserts reg_write and wb_sel = 01; 8 cycles total.
- Branch with bcond = 0 in EX_BR1 → pc_write_en = 1, pc_source = 0, back to IF (3 cycles). With bcond = 1 → EX_BR1 has pc_write_en = 0, then EX_BR2 has pc_source = 1, pc_write_en = 1 (4 cycles).
- ECALL (1110011) with halt_req = 1 → HALT, is_halted = 1 for 20+ cycles, no enables. With halt_req = 0 → EX_NOP, PC advances.
- reset driven low during the 2nd cycle of EX_LD (MEM_LATENCY = 3) → at the next edge state = IF, counter = 0, mdr_write never asserted.
- With MC_CTRL_STATS_EN, run R, load, taken branch at MEM_LATENCY = 1 → retired_count = 3, cycle_count = 11 at the final IF entry.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control-unit handshake bundle: IR opcode and ALU flags in,
// datapath enables and mux selects out.
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_req;
  logic       pc_write_en;
  logic       pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mdr_write;
  logic       alu_out_reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       is_halted;

  modport master (
    output opcode, bcond, halt_req,
    input  pc_write_en, pc_source, i_or_d,
    input  mem_read, mem_write, ir_write,
    input  mdr_write, alu_out_reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  reg_write, wb_sel, is_halted
  );

  modport slave (
    input  opcode, bcond, halt_req,
    output pc_write_en, pc_source, i_or_d,
    output mem_read, mem_write, ir_write,
    output mdr_write, alu_out_reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output reg_write, wb_sel, is_halted
  );
endinterface

// File: rtl/mc_control_fsm.sv
// RV32I multi-cycle control FSM (IF/ID/EX/WB sequencing).
// Optional MC_CTRL_STATS_EN adds cycle_count and retired_count.
module mc_control_fsm #(
  parameter int MEM_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  mc_control_fsm_if.slave ctl
`ifdef MC_CTRL_STATS_EN
  ,
  output logic [31:0] retired_count,
  output logic [31:0] cycle_count
`endif
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [3:0] LAST    = 4'(MEM_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I,
    S_EX_LD, S_WB_LD, S_EX_ST,
    S_EX_BR1, S_EX_BR2, S_EX_JAL,
    S_EX_JALR, S_EX_NOP, S_HALT
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;
  logic       last;

  assign last = (cnt == LAST);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IF:     if (last) nxt = S_ID;
      S_ID: begin
        unique case (1'b1)
          (ctl.opcode == OP_R):    nxt = S_EX_R;
          (ctl.opcode == OP_I):    nxt = S_EX_I;
          (ctl.opcode == OP_LD):   nxt = S_EX_LD;
          (ctl.opcode == OP_ST):   nxt = S_EX_ST;
          (ctl.opcode == OP_BR):   nxt = S_EX_BR1;
          (ctl.opcode == OP_JAL):  nxt = S_EX_JAL;
          (ctl.opcode == OP_JALR): nxt = S_EX_JALR;
          (ctl.opcode == OP_SYS):
            nxt = ctl.halt_req ? S_HALT : S_EX_NOP;
          default:                 nxt = S_EX_NOP;
        endcase
      end
      S_EX_LD:  if (last) nxt = S_WB_LD;
      S_EX_ST:  if (last) nxt = S_IF;
      S_EX_BR1: nxt = ctl.bcond ? S_EX_BR2 : S_IF;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IF;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (state != S_HALT)
        cnt <= cnt + 4'd1;
    end
  end

  // Outputs held low while reset is asserted so an abandoned access
  // never fires an enable in the reset cycle.
  always_comb begin
    ctl.pc_write_en       = 1'b0;
    ctl.pc_source         = 1'b0;
    ctl.i_or_d            = 1'b0;
    ctl.mem_read          = 1'b0;
    ctl.mem_write         = 1'b0;
    ctl.ir_write          = 1'b0;
    ctl.mdr_write         = 1'b0;
    ctl.alu_out_reg_write = 1'b0;
    ctl.alu_src_a         = 1'b0;
    ctl.alu_src_b         = 2'b00;
    ctl.alu_op            = 2'b00;
    ctl.reg_write         = 1'b0;
    ctl.wb_sel            = 2'b00;
    ctl.is_halted         = 1'b0;
    if (reset) begin
      unique case (state)
        S_IF: begin
          ctl.mem_read          = 1'b1;
          ctl.alu_src_b         = 2'b01;
          ctl.ir_write          = last;
          ctl.alu_out_reg_write = last;
        end
        S_EX_R, S_EX_I: begin
          ctl.alu_src_a   = 1'b1;
          ctl.alu_src_b   = (state == S_EX_I) ? 2'b10 : 2'b00;
          ctl.alu_op      = 2'b10;
          ctl.reg_write   = 1'b1;
          ctl.pc_write_en = 1'b1;
        end
        S_EX_LD: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = 2'b10;
          ctl.i_or_d    = 1'b1;
          ctl.mem_read  = 1'b1;
          ctl.mdr_write = last;
        end
        S_WB_LD: begin
          ctl.reg_write   = 1'b1;
          ctl.wb_sel      = 2'b01;
          ctl.pc_write_en = 1'b1;
        end
        S_EX_ST: begin
          ctl.alu_src_a   = 1'b1;
          ctl.alu_src_b   = 2'b10;
          ctl.i_or_d      = 1'b1;
          ctl.mem_write   = 1'b1;
          ctl.pc_write_en = last;
        end
        S_EX_BR1: begin
          ctl.alu_src_a   = 1'b1;
          ctl.alu_op      = 2'b01;
          ctl.pc_write_en = ~ctl.bcond;
        end
        S_EX_BR2: begin
          ctl.alu_src_b   = 2'b10;
          ctl.pc_source   = 1'b1;
          ctl.pc_write_en = 1'b1;
        end
        S_EX_JAL, S_EX_JALR: begin
          ctl.alu_src_a   = (state == S_EX_JALR);
          ctl.alu_src_b   = 2'b10;
          ctl.reg_write   = 1'b1;
          ctl.wb_sel      = 2'b10;
          ctl.pc_source   = 1'b1;
          ctl.pc_write_en = 1'b1;
        end
        S_EX_NOP: ctl.pc_write_en = 1'b1;
        S_HALT:   ctl.is_halted   = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_STATS_EN
  logic retire;

  assign retire = (nxt == S_IF && state != S_IF) ||
                  (nxt == S_HALT && state != S_HALT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (state != S_HALT)
        cycle_count <= cycle_count + 32'd1;
      if (retire)
        retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule
